// File: rtl/arb8_way16.sv
// Round-robin arbiter for eight 16-bit requesters feeding one registered output word
// drained through a valid/ready handshake; up to BURST words per grant.

module Mux8Way16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic [15:0] c_i,
   input  logic [15:0] d_i,
   input  logic [15:0] e_i,
   input  logic [15:0] f_i,
   input  logic [15:0] g_i,
   input  logic [15:0] h_i,
   input  logic [2:0]  sel_i,
   output logic [15:0] out_o
);
   always_comb begin
      out_o = a_i;
      case (sel_i)
         3'd0:    out_o = a_i;
         3'd1:    out_o = b_i;
         3'd2:    out_o = c_i;
         3'd3:    out_o = d_i;
         3'd4:    out_o = e_i;
         3'd5:    out_o = f_i;
         3'd6:    out_o = g_i;
         3'd7:    out_o = h_i;
         default: out_o = a_i;
      endcase
   end
endmodule

// Handshake: out is transferred on a rising edge where out_valid & out_ready are both 1;
// gnt[i] marks the cycle in which word i is sampled into out.
module arb8_way16 #(
   parameter int unsigned BURST = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  req,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [15:0] e,
   input  logic [15:0] f,
   input  logic [15:0] g,
   input  logic [15:0] h,
   output logic [7:0]  gnt,
   output logic [2:0]  sel,
   output logic [15:0] out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  dbg_o
);
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   localparam logic [3:0] BURST_C = 4'(BURST);

   state_e      state_q, state_d;
   logic [2:0]  ptr_q, ptr_d;
   logic [2:0]  sel_q, sel_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] out_q, out_d;
   logic        valid_q, valid_d;

   logic [2:0]  winner;
   logic [2:0]  idx;
   logic        any_req;
   logic [2:0]  mux_sel;
   logic [15:0] mux_out;
   logic [7:0]  gnt_c;

   // Scan from farthest to nearest so the closest requester to ptr wins.
   always_comb begin
      winner  = 3'd0;
      any_req = 1'b0;
      idx     = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         idx = ptr_q + 3'(k);
         if (req[idx]) begin
            winner  = idx;
            any_req = 1'b1;
         end
      end
   end

   // In IDLE the mux must already show the winner so it can be captured on the grant edge.
   assign mux_sel = (state_q == IDLE) ? winner : sel_q;

   Mux8Way16 u_mux (
      .a_i   (a),
      .b_i   (b),
      .c_i   (c),
      .d_i   (d),
      .e_i   (e),
      .f_i   (f),
      .g_i   (g),
      .h_i   (h),
      .sel_i (mux_sel),
      .out_o (mux_out)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      valid_d = valid_q;
      gnt_c   = 8'd0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_c   = 8'd1 << winner;
               sel_d   = winner;
               out_d   = mux_out;
               valid_d = 1'b1;
               cnt_d   = 4'd1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (out_ready) begin
               if (req[sel_q] && (cnt_q < BURST_C)) begin
                  gnt_c = 8'd1 << sel_q;
                  out_d = mux_out;
                  cnt_d = cnt_q + 4'd1;
               end else begin
                  valid_d = 1'b0;
                  ptr_d   = sel_q + 3'd1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         sel_q   <= 3'd0;
         cnt_q   <= 4'd0;
         out_q   <= 16'h0000;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign gnt       = reset_n ? gnt_c : 8'd0;
   assign sel       = sel_q;
   assign out       = out_q;
   assign out_valid = valid_q;
   assign dbg_o     = {state_q, ptr_q, cnt_q};

endmodule
